pod_power_sequencer: RTL and testbench

- Multi-pod power controller for the logic-pod connectors.
- Each pod gets a per-pod mate/fault state machine: mate delay, fault latch, and a clear delay after unplug.
- A shared round-robin scheduler lets only one pod switch on per inrush window, which keeps the combined inrush current within the shared supply budget.
- Sits between the pod connector I/O and the management register block. That block supplies the disable mask and reads the status outputs.

---
 rtl/pod_power_pkg.sv | 13 +
 rtl/pod_power_channel.sv | 63 ++++++
 rtl/pod_power_sequencer.sv | 66 ++++++
 tb/tb_pod_power_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pod_power_pkg.sv
// pod_power_pkg: shared pod state encoding and 125 MHz timing defaults.
package pod_power_pkg;
    typedef enum logic [2:0] {
        OFF,
        MATING,
        WAIT_GRANT,
        ON,
        FAULT,
        CLEARING
    } pod_state_t;
    localparam int DEF_MATE_BITS     = 26;
    localparam int DEF_INRUSH_CYCLES = 1250000;
endpackage

// File: rtl/pod_power_channel.sv
// pod_power_channel: one pod's mate/fault state machine with its mate/clear delay counter.
module pod_power_channel
    import pod_power_pkg::*;
#(
    parameter int MATE_BITS = DEF_MATE_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic present_n,
    input  logic fault_n,
    input  logic hold_off,
    input  logic grant,
    output logic request,
    output logic power_en,
    output logic fault_latched,
    output logic waiting
);
    pod_state_t state, state_next;
    logic [MATE_BITS-1:0] count, count_next;
    logic leave;
    assign leave = present_n | hold_off;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end
    // Mate and clear delays both end when the counter wraps back to zero.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            OFF: if (!leave) begin
                state_next = MATING;
                count_next = MATE_BITS'(1);
            end
            MATING: if (leave) state_next = OFF;
                    else if (count == '0) state_next = WAIT_GRANT;
                    else count_next = count + 1'b1;
            WAIT_GRANT: if (leave) state_next = OFF;
                        else if (grant) state_next = ON;
            ON: if (!fault_n) state_next = FAULT;
                else if (leave) state_next = OFF;
            FAULT: if (present_n) begin
                state_next = CLEARING;
                count_next = MATE_BITS'(1);
            end
            CLEARING: if (count == '0) state_next = OFF;
                      else count_next = count + 1'b1;
            default: state_next = OFF;
        endcase
    end
    // A request is withdrawn in the same cycle the pod is unplugged or disabled.
    always_comb begin
        request       = state == WAIT_GRANT && !leave;
        power_en      = state == ON;
        fault_latched = state == FAULT || state == CLEARING;
        waiting       = state == WAIT_GRANT;
    end
endmodule

// File: rtl/pod_power_sequencer.sv
// pod_power_sequencer: per-pod power FSMs sharing a round-robin, inrush-spaced power-on scheduler.
module pod_power_sequencer
    import pod_power_pkg::*;
#(
    parameter int NUM_PODS      = 8,
    parameter int MATE_BITS     = DEF_MATE_BITS,
    parameter int INRUSH_CYCLES = DEF_INRUSH_CYCLES
) (
    input  logic                clk_125mhz,
    input  logic                rst,
    input  logic [NUM_PODS-1:0] pod_present_n,
    input  logic [NUM_PODS-1:0] pod_power_fault_n,
    input  logic [NUM_PODS-1:0] pod_disable,
    output logic [NUM_PODS-1:0] pod_power_en,
    output logic [NUM_PODS-1:0] pod_fault_latched,
    output logic [NUM_PODS-1:0] pod_waiting,
    output logic                inrush_busy
);
    localparam int PTR_W = NUM_PODS > 1 ? $clog2(NUM_PODS) : 1;
    localparam int TMR_W = $clog2(INRUSH_CYCLES + 1);
    logic [NUM_PODS-1:0] request, grant;
    logic [PTR_W-1:0] rr_ptr, grant_idx;
    logic [TMR_W-1:0] timer;
    logic grant_valid;
    for (genvar i = 0; i < NUM_PODS; i++) begin : g_pod
        pod_power_channel #(.MATE_BITS(MATE_BITS)) u_channel (
            .clk          (clk_125mhz),
            .rst          (rst),
            .present_n    (pod_present_n[i]),
            .fault_n      (pod_power_fault_n[i]),
            .hold_off     (pod_disable[i]),
            .grant        (grant[i]),
            .request      (request[i]),
            .power_en     (pod_power_en[i]),
            .fault_latched(pod_fault_latched[i]),
            .waiting      (pod_waiting[i])
        );
    end
    // Scan downwards so the requester nearest after rr_ptr is the one kept.
    // Granting on the timer's last count spaces grants exactly INRUSH_CYCLES edges apart.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_PODS; k >= 1; k--) begin
            automatic int idx = (int'(rr_ptr) + k) % NUM_PODS;
            if (request[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
        if (timer > TMR_W'(1)) grant_valid = 1'b0;
        grant = grant_valid ? NUM_PODS'(1) << grant_idx : '0;
    end
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            timer  <= '0;
            rr_ptr <= '0;
        end else if (grant_valid) begin
            timer  <= TMR_W'(INRUSH_CYCLES);
            rr_ptr <= grant_idx;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end
    assign inrush_busy = timer != '0;
endmodule

// File: tb/tb_pod_power_sequencer.sv
// tb_pod_power_sequencer: timestamp-based reference model, directed latency/fairness checks, random soak.
module tb_pod_power_sequencer;
    localparam int NP = 4, MB = 4, IC = 8, MT = 1 << MB;
    localparam int S_OFF = 0, S_MATE = 1, S_WAIT = 2, S_ON = 3, S_FLT = 4, S_CLR = 5;
    logic clk = 0, rst = 1;
    logic [NP-1:0] present_n = '1, fault_n = '1, dis = '0;
    logic [NP-1:0] en, fl, wt;
    logic busy;
    always #5 clk = ~clk;
    pod_power_sequencer #(.NUM_PODS(NP), .MATE_BITS(MB), .INRUSH_CYCLES(IC)) dut (
        .clk_125mhz       (clk),
        .rst              (rst),
        .pod_present_n    (present_n),
        .pod_power_fault_n(fault_n),
        .pod_disable      (dis),
        .pod_power_en     (en),
        .pod_fault_latched(fl),
        .pod_waiting      (wt),
        .inrush_busy      (busy)
    );
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int st[NP], t0[NP], ns[NP];
    int rr, last_g, g;
    bit has_g, chk;
    logic [NP-1:0] e_en, e_fl, e_wt;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask
    // Reference model: pods tracked by state plus entry edge, inrush by last-grant edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int p = 0; p < NP; p++) st[p] = S_OFF;
            rr = 0;
            has_g = 0;
        end else begin
            g = -1;
            if (!has_g || cyc - last_g >= IC)
                for (int k = 1; k <= NP; k++)
                    if (g < 0 && st[(rr+k)%NP] == S_WAIT && !present_n[(rr+k)%NP] && !dis[(rr+k)%NP])
                        g = (rr + k) % NP;
            for (int p = 0; p < NP; p++) begin
                ns[p] = st[p];
                case (st[p])
                    S_OFF: if (!present_n[p] && !dis[p]) begin ns[p] = S_MATE; t0[p] = cyc; end
                    S_MATE: if (present_n[p] || dis[p]) ns[p] = S_OFF;
                            else if (cyc - t0[p] == MT) ns[p] = S_WAIT;
                    S_WAIT: if (present_n[p] || dis[p]) ns[p] = S_OFF;
                            else if (p == g) ns[p] = S_ON;
                    S_ON: if (!fault_n[p]) ns[p] = S_FLT;
                          else if (present_n[p] || dis[p]) ns[p] = S_OFF;
                    S_FLT: if (present_n[p]) begin ns[p] = S_CLR; t0[p] = cyc; end
                    S_CLR: if (cyc - t0[p] == MT) ns[p] = S_OFF;
                    default: ;
                endcase
            end
            for (int p = 0; p < NP; p++) st[p] = ns[p];
            if (g >= 0) begin
                rr = g;
                last_g = cyc;
                has_g = 1;
            end
        end
    end
    always @(negedge clk) begin
        if (chk) begin
            for (int p = 0; p < NP; p++) begin
                e_en[p] = st[p] == S_ON;
                e_fl[p] = st[p] == S_FLT || st[p] == S_CLR;
                e_wt[p] = st[p] == S_WAIT;
            end
            check("model_en", 32'(en), 32'(e_en));
            check("model_fault", 32'(fl), 32'(e_fl));
            check("model_wait", 32'(wt), 32'(e_wt));
            check("model_busy", 32'(busy), 32'(has_g && (cyc - last_g) < IC));
        end
    end
    task automatic wait_en(input int p, output int e);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en[p]) begin
                e = cyc;
                return;
            end
        end
        e = -1;
    endtask
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1; present_n = '1; fault_n = '1; dis = '0;
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end
    initial begin
        int e0, e, e3, u, n;
        int rise[NP];
        repeat (3) @(negedge clk);
        rst = 0;
        chk = 1;
        check("reset_en", 32'(en), 0);
        check("reset_fault", 32'(fl), 0);
        check("reset_wait", 32'(wt), 0);
        check("reset_busy", 32'(busy), 0);
        // single mate
        @(negedge clk);
        present_n[0] = 0;
        e0 = cyc + 1;
        repeat (17) @(negedge clk);
        check("wait_at_16", 32'(wt[0]), 1);
        check("no_en_at_16", 32'(en[0]), 0);
        @(negedge clk);
        check("en_at_17", 32'(en), 32'h1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, IC);
        // simultaneous mate: rr_ptr=0 so search starts at pod 1
        pulse_reset();
        @(negedge clk);
        present_n = '0;
        e0 = cyc + 1;
        for (int p = 0; p < NP; p++) rise[p] = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (en[p] && rise[p] < 0) rise[p] = cyc;
        end
        for (int k = 0; k < NP; k++) check($sformatf("rise_pod%0d", (1 + k) % NP), rise[(1+k)%NP] - e0, 17 + IC * k);
        // round robin from rr_ptr=1
        pulse_reset();
        @(negedge clk);
        present_n[1] = 0;
        wait_en(1, e);
        repeat (10) @(negedge clk);
        present_n[0] = 0; present_n[3] = 0;
        e0 = cyc + 1;
        wait_en(3, e3);
        check("rr_pod3_first", e3 - e0, 17);
        wait_en(0, e);
        check("rr_pod0_next", e - e3, IC);
        // fault in ON, clearing, re-mate
        @(negedge clk);
        present_n[2] = 0;
        wait_en(2, e);
        check("pod2_on", 32'(e > 0), 1);
        @(negedge clk);
        fault_n[2] = 0;
        @(negedge clk);
        fault_n[2] = 1;
        check("fault_en_off", 32'(en[2]), 0);
        check("fault_latched", 32'(fl[2]), 1);
        repeat (20) @(negedge clk);
        check("replug_ignored", 32'({fl[2], en[2]}), 2);
        present_n[2] = 1;
        u = cyc + 1;
        repeat (5) @(negedge clk);
        present_n[2] = 0;
        while (cyc < u + 15) @(negedge clk);
        check("clearing_held", 32'(fl[2]), 1);
        @(negedge clk);
        check("clearing_done", 32'(fl[2]), 0);
        wait_en(2, e);
        check("remate_on", e - u, 34);
        // simultaneous fault and unplug
        @(negedge clk);
        fault_n[2] = 0; present_n[2] = 1;
        @(negedge clk);
        fault_n[2] = 1;
        check("fault_over_unplug", 32'({fl[2], en[2]}), 2);
        repeat (10) @(negedge clk);
        check("clearing_not_off", 32'(fl[2]), 1);
        repeat (20) @(negedge clk);
        // unplug mid-mating
        present_n[2] = 0;
        e0 = cyc + 1;
        while (cyc < e0 + 7) @(negedge clk);
        present_n[2] = 1;
        repeat (30) @(negedge clk);
        check("abort_mate", 32'({wt[2], en[2], busy}), 0);
        // disable in ON and in WAIT_GRANT
        dis[0] = 1;
        @(negedge clk);
        check("disable_on", 32'(en[0]), 0);
        present_n[2] = 0;
        for (int i = 0; i < 40 && !wt[2]; i++) @(negedge clk);
        dis[2] = 1;
        @(negedge clk);
        check("disable_wait", 32'({wt[2], en[2], busy}), 0);
        // reset mid-inrush with pods 1 and 3 on
        dis = '0;
        for (int i = 0; i < 60 && !busy; i++) @(negedge clk);
        check("busy_before_rst", 32'(busy), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_outputs", 32'({en, fl, wt, busy}), 0);
        // random soak
        repeat (4000) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 39) == 0) present_n[p] = ~present_n[p];
                if ($urandom_range(0, 99) == 0) dis[p] = ~dis[p];
                fault_n[p] = $urandom_range(0, 59) != 0;
            end
            rst = $urandom_range(0, 1499) == 0;
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
